// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port: grants one of four requesters,
// runs a valid/ready transaction to memory and aborts it if memory stays silent.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       mem_valid,
  output logic [3:0] done,
  output logic       err
);

  // Memory handshake: mem_valid is high for the whole transaction, and the
  // transaction ends on the first rising edge where mem_ready is sampled high.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [0:0]       state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       timeout;
  logic       finish;
  logic [1:0] next_ptr;
  logic [3:0] cand;
  logic [2:0] win;

  // Returns {found, index}; the lowest offset from start wins.
  function automatic logic [2:0] pick(input logic [3:0] c, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (c[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    timeout = 1'b0;
    if (TIMEOUT > 0)
      timeout = (state == BUSY) && !mem_ready && (cnt == TO_LAST);
    finish   = (state == BUSY) && (mem_ready || timeout);
    next_ptr = finish ? sel + 2'd1 : ptr;
    // The requester just served sits out the arbitration on its completion edge.
    cand     = (state == BUSY) ? (req & ~gnt) : req;
    win      = pick(cand, next_ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      gnt       <= 4'b0000;
      sel       <= 2'd0;
      mem_valid <= 1'b0;
      done      <= 4'b0000;
      err       <= 1'b0;
    end else begin
      done <= 4'b0000;
      err  <= 1'b0;
      if (state == IDLE || finish) begin
        if (finish) begin
          ptr <= next_ptr;
          cnt <= '0;
          if (mem_ready) done <= gnt;
          else           err  <= 1'b1;
        end
        if (win[2]) begin
          gnt       <= 4'b0001 << win[1:0];
          sel       <= win[1:0];
          mem_valid <= 1'b1;
          cnt       <= '0;
          state     <= BUSY;
        end else begin
          gnt       <= 4'b0000;
          mem_valid <= 1'b0;
          state     <= IDLE;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed stimulus for mem_port_arbiter, checked cycle by cycle
// against a queue-fed reference model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int W       = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       mem_ready = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       mem_valid;
  logic [3:0] done;
  logic       err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .mem_ready(mem_ready),
    .gnt(gnt), .sel(sel), .mem_valid(mem_valid), .done(done), .err(err)
  );

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, where the rotation resumes, and how
  // many silent cycles the current owner has waited.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] c, input int start);
    for (int k = 0; k < 4; k++)
      if (c[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] d;
    logic       e;
    logic [3:0] c;
    int         w;
    bit         fin;
    d = 4'b0000;
    e = 1'b0;
    fin = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_wait = 0;
    end else if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_wait = 0;
      end
    end else begin
      if (mem_ready) begin
        d = 4'(1 << m_owner); fin = 1'b1;
      end else if (TIMEOUT > 0 && m_wait + 1 == TIMEOUT) begin
        e = 1'b1; fin = 1'b1;
      end else begin
        m_wait++;
      end
      if (fin) begin
        m_ptr = (m_owner + 1) % 4;
        c = req & ~4'(1 << m_owner);
        w = pick(c, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_wait = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
    exp_q.push_back({m_busy ? 4'(1 << m_owner) : 4'b0000, 2'(m_owner), m_busy, d, e});
  end

  always @(negedge clk) begin : monitor
    logic [W-1:0] x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("gnt", 32'(gnt), 32'(x[11:8]));
      chk("sel", 32'(sel), 32'(x[7:6]));
      chk("mem_valid", 32'(mem_valid), 32'(x[5]));
      chk("done", 32'(done), 32'(x[4:1]));
      chk("err", 32'(err), 32'(x[0]));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("valid_vs_gnt", 32'(mem_valid), 32'(gnt != 4'b0000));
      chk("done_err_excl", 32'((done != 4'b0000) && err), 32'd0);
    end
  end

  task automatic step(input logic [3:0] r, input logic m);
    @(negedge clk);
    req = r;
    mem_ready = m;
  endtask

  task automatic async_reset(input logic [3:0] r_after);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    req = r_after;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // single request, memory answers on the fourth busy cycle
    step(4'b0010, 1'b0);
    repeat (3) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    repeat (2) step(4'b0000, 1'b0);

    // everyone requesting, memory always ready: back-to-back rotation
    repeat (10) step(4'b1111, 1'b1);
    repeat (2) step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // served requester masked on its own completion edge
    step(4'b0100, 1'b0);
    repeat (2) step(4'b0000, 1'b0);
    step(4'b0100, 1'b1);
    repeat (2) step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // watchdog abort on requester 3 with requester 0 waiting
    step(4'b1000, 1'b0);
    repeat (16) step(4'b1001, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // memory answers on the very cycle the watchdog would fire
    step(4'b0010, 1'b0);
    repeat (14) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    repeat (2) step(4'b0000, 1'b0);

    // reset in the middle of a transaction owned by requester 2
    step(4'b0100, 1'b0);
    repeat (3) step(4'b0000, 1'b0);
    async_reset(4'b0110);
    step(4'b0110, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // random traffic with slow memory and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0)
        async_reset(4'($urandom_range(0, 15)));
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    repeat (3) step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing the single memory port between up to four requesters: fetch, load/store, debug and DMA.
- Drives the 2-bit select of the 32-bit 4:1 address/data mux in front of memory.
- Sequences each transaction with a valid/ready handshake to memory and signals completion back to the winner.
- Has a watchdog that aborts transactions when memory never answers.

Parameters:
- TIMEOUT, 15, number of BUSY cycles without mem_ready before abort; 0 disables the watchdog.
- CNT_W, 4, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  per-requester request; bit i = requester i.
- mem_ready  input  1  memory completes the current transaction this cycle.
- gnt  output  4  one-hot grant; all-zero when idle.
- sel  output  2  mux select = index of granted requester.
- mem_valid  output  1  transaction in flight to memory.
- done  output  4  one-cycle one-hot completion pulse to the served requester.
- err  output  1  one-cycle pulse: current transaction aborted by watchdog.

Behaviour:
- All outputs are registered.
- Reset, asynchronous while rst=1: gnt=0, sel=0, mem_valid=0, done=0, err=0, rr pointer ptr=0, watchdog counter=0, state=IDLE.
- States: IDLE, BUSY.
- Arbitration function: pick the first asserted bit of the candidate vector, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
- IDLE:
  - If req!=0 at an edge: the candidate vector is req. Next cycle gnt=onehot(w), sel=w, mem_valid=1, counter=0, state=BUSY.
  - Latency from req sampled to gnt visible: 1 cycle.
  - If req=0: stay in IDLE. gnt=0 and mem_valid=0; sel holds its last value.
  - mem_ready in IDLE is ignored.
- BUSY:
  - gnt, sel and mem_valid hold.
  - req of the granted requester may drop after grant; the transaction still runs to completion.
  - The counter increments each BUSY cycle without mem_ready.
- Completion, an edge in BUSY with mem_ready=1:
  - done[sel]=1 for exactly the next cycle.
  - ptr=sel+1 mod 4; counter=0.
  - Re-arbitration happens on the same edge with candidate vector req & ~gnt. The just-served requester is masked for that one edge, so it can be regranted no earlier than the following arbitration.
  - If the candidate vector is non-zero: go back-to-back. The new gnt/sel/mem_valid=1 take effect the next cycle with no idle bubble, and state stays BUSY.
  - Otherwise: gnt=0, mem_valid=0, state=IDLE.
- Timeout, TIMEOUT>0, edge in BUSY with counter==TIMEOUT-1 and mem_ready=0:
  - Abort: err=1 for one cycle; done stays 0.
  - ptr advances and re-arbitration proceeds exactly as for completion.
- Simultaneous timeout and mem_ready on the same edge: mem_ready wins, so done pulses and err stays 0.
- Invariants:
  - gnt is always zero or one-hot.
  - mem_valid==(gnt!=0).
  - done and err are never set together.
- Reset mid-transaction: all outputs clear immediately, no done is produced, and the memory side must treat the transaction as dropped.

Test Plan:
- Reset then req=4'b0010 → gnt=4'b0010, sel=1, mem_valid=1 one cycle later; mem_ready after 3 cycles → done=4'b0010 one cycle, then gnt=0, mem_valid=0.
- req=4'b1111 held, mem_ready=1 every BUSY cycle → grants rotate sel=0,1,2,3,0 back-to-back, mem_valid continuously 1, no idle cycles.
- Grant held on requester 2, req=4'b0100 only at completion → gnt drops to 0 for at least one cycle before requester 2 is regranted (mask check).
- TIMEOUT=15, grant requester 3, mem_ready never → err pulse one cycle after 15 BUSY cycles, done=0, ptr=0; with req[0]=1 pending, gnt=4'b0001 the next cycle.
- mem_ready asserted on the 15th BUSY cycle, simultaneous with the timeout → done pulses, err stays 0.
- rst asserted mid-BUSY while sel=2 → gnt=0, mem_valid=0, sel=0 with no clock edge; after release with req=4'b0110, requester 1 is granted first (ptr=0).
